la_trigger_capture: RTL and testbench

Parametrised, triggerable logic-analyser capture buffer for NF2.1 user-datapath modules. It keeps a rolling pre-trigger history of qualified samples in a circular block RAM and triggers on a masked pattern compare or an external strobe. After the trigger it captures a programmable number of post-trigger samples, then freezes. Software reads the frozen record back 32 bits at a time through the owning module's generic_regs hardware registers, with the oldest sample at logical index 0.

---
 rtl/la_trigger_capture_if.sv | 32 +++
 rtl/la_trigger_capture.sv | 90 +++++++++
 tb/tb_la_trigger_capture.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/la_trigger_capture_if.sv
// la_trigger_capture_if: control, probe and readback signals of the logic-analyser capture buffer.
interface la_trigger_capture_if #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 10,
  parameter int SEL_WIDTH  = 3
);
  logic                  arm;
  logic                  clear;
  logic                  sample_en;
  logic                  ext_trig;
  logic [DATA_WIDTH-1:0] capture_data;
  logic [DATA_WIDTH-1:0] trig_mask;
  logic [DATA_WIDTH-1:0] trig_value;
  logic [ADDR_WIDTH-1:0] post_count;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [SEL_WIDTH-1:0]  word_select;
  logic [31:0]           data_out;
  logic [1:0]            state;
  logic                  triggered;
  logic [ADDR_WIDTH:0]   samples_captured;
  logic [ADDR_WIDTH-1:0] trig_index;
  modport master (
    output arm, clear, sample_en, ext_trig, capture_data, trig_mask, trig_value,
           post_count, read_addr, word_select,
    input  data_out, state, triggered, samples_captured, trig_index
  );
  modport slave (
    input  arm, clear, sample_en, ext_trig, capture_data, trig_mask, trig_value,
           post_count, read_addr, word_select,
    output data_out, state, triggered, samples_captured, trig_index
  );
endinterface

// File: rtl/la_trigger_capture.sv
// la_trigger_capture: triggerable logic-analyser capture buffer with circular pre-trigger history.
module la_trigger_capture #(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 10,
  parameter int SEL_WIDTH  = 3
) (
  input logic clk,
  input logic reset,
  la_trigger_capture_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PAD_W = (2**SEL_WIDTH)*32;
  typedef enum logic [1:0] {IDLE, PRETRIG, POSTTRIG, DONE} state_t;
  state_t                st, st_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n, post_done, post_done_n, phys;
  logic [ADDR_WIDTH:0]   cnt, cnt_n, tidx;
  logic                  trig, trig_n, we, hit, rd_vld;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic [PAD_W-1:0]      rd_pad;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [31:0]           dout;
  assign hit = bus.sample_en & ((((bus.capture_data ^ bus.trig_value) & bus.trig_mask) == '0) | bus.ext_trig);
  // post_count is ADDR_WIDTH bits wide, so it can never exceed DEPTH-1 and needs no clamp
  always_comb begin
    st_n = st;
    wr_ptr_n = wr_ptr;
    cnt_n = cnt;
    post_done_n = post_done;
    trig_n = trig;
    we = 1'b0;
    if (bus.clear || bus.arm) begin
      st_n = bus.clear ? IDLE : PRETRIG;
      wr_ptr_n = '0;
      cnt_n = '0;
      post_done_n = '0;
      trig_n = 1'b0;
    end else if ((st == PRETRIG || st == POSTTRIG) && bus.sample_en) begin
      we = 1'b1;
      wr_ptr_n = wr_ptr + 1'b1;
      cnt_n = cnt[ADDR_WIDTH] ? cnt : cnt + 1'b1;
      if (st == POSTTRIG) begin
        post_done_n = post_done + 1'b1;
        st_n = (post_done_n == bus.post_count) ? DONE : POSTTRIG;
      end else if (hit) begin
        trig_n = 1'b1;
        st_n = (bus.post_count == '0) ? DONE : POSTTRIG;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      wr_ptr <= '0;
      cnt <= '0;
      post_done <= '0;
      trig <= 1'b0;
    end else begin
      st <= st_n;
      wr_ptr <= wr_ptr_n;
      cnt <= cnt_n;
      post_done <= post_done_n;
      trig <= trig_n;
    end
  end
  // once full, cnt's low bits are zero and wr_ptr already points at the oldest sample
  assign phys = wr_ptr - cnt[ADDR_WIDTH-1:0] + bus.read_addr;
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= bus.capture_data;
    rd_q <= mem[phys];
  end
  assign rd_pad = PAD_W'(rd_q);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld <= 1'b0;
      sel_q <= '0;
      dout <= '0;
    end else begin
      rd_vld <= {1'b0, bus.read_addr} < cnt;
      sel_q <= bus.word_select;
      dout <= rd_vld ? rd_pad[32*sel_q +: 32] : '0;
    end
  end
  assign tidx = cnt - 1'b1 - {1'b0, post_done};
  assign bus.data_out = dout;
  assign bus.state = st;
  assign bus.triggered = trig;
  assign bus.samples_captured = cnt;
  assign bus.trig_index = trig ? tidx[ADDR_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_la_trigger_capture.sv
// tb_la_trigger_capture: scoreboard bench for la_trigger_capture with DEPTH=16, 72-bit samples.
module tb_la_trigger_capture;
  localparam int K_DATA = 0, K_STATE = 1, K_CNT = 2, K_TIDX = 3, K_TRIG = 4;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int          q_kind[$];
  int          q_due[$];
  logic [31:0] q_exp[$];
  string       q_name[$];
  la_trigger_capture_if #(.DATA_WIDTH(72), .ADDR_WIDTH(4), .SEL_WIDTH(3)) bus ();
  la_trigger_capture #(.DATA_WIDTH(72), .ADDR_WIDTH(4), .SEL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] act(input int k);
    case (k)
      K_DATA:  return bus.data_out;
      K_STATE: return 32'(bus.state);
      K_CNT:   return 32'(bus.samples_captured);
      K_TIDX:  return 32'(bus.trig_index);
      default: return 32'(bus.triggered);
    endcase
  endfunction
  initial forever begin
    @(negedge clk);
    while (q_due.size() > 0 && q_due[0] <= cyc) begin
      int          k;
      logic [31:0] e, a;
      string       n;
      k = q_kind.pop_front();
      e = q_exp.pop_front();
      n = q_name.pop_front();
      void'(q_due.pop_front());
      a = act(k);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int k, input string n, input logic [31:0] e, input int d);
    q_kind.push_back(k);
    q_name.push_back(n);
    q_exp.push_back(e);
    q_due.push_back(cyc + d);
  endtask
  task automatic chk(input int k, input string n, input logic [31:0] e);
    push(k, n, e, 0);
  endtask
  task automatic smp(input logic [71:0] d, input logic en);
    bus.capture_data = d;
    bus.sample_en = en;
    step();
    bus.sample_en = 1'b0;
  endtask
  task automatic do_arm();
    bus.arm = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask
  task automatic rd(input int a, input int w, input logic [31:0] e, input string n);
    bus.read_addr = 4'(a);
    bus.word_select = 3'(w);
    push(K_DATA, n, e, 2);
    step();
    step();
  endtask
  task automatic cfg(input logic [71:0] m, input logic [71:0] v, input int p);
    bus.trig_mask = m;
    bus.trig_value = v;
    bus.post_count = 4'(p);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1;
    bus.arm = 1'b0;
    bus.clear = 1'b0;
    bus.sample_en = 1'b0;
    bus.ext_trig = 1'b0;
    bus.capture_data = '0;
    bus.read_addr = '0;
    bus.word_select = '0;
    cfg(72'h0, 72'h0, 0);
    step();
    step();
    reset = 1'b0;
    chk(K_STATE, "rst_state", 0);
    chk(K_CNT, "rst_cnt", 0);
    chk(K_TIDX, "rst_tidx", 0);
    chk(K_TRIG, "rst_trig", 0);
    chk(K_DATA, "rst_data", 0);
    step();
    // immediate trigger on all-zero mask
    cfg(72'h0, 72'h0, 3);
    do_arm();
    chk(K_STATE, "imm_armed", 1);
    for (int i = 1; i <= 5; i++) begin
      smp(72'(i), 1'b1);
      if (i == 1) begin
        chk(K_STATE, "imm_post", 2);
        chk(K_TRIG, "imm_trig", 1);
      end
      if (i == 4) chk(K_STATE, "imm_done", 3);
    end
    chk(K_CNT, "imm_cnt", 4);
    chk(K_TIDX, "imm_tidx", 0);
    rd(0, 0, 1, "imm_l0");
    rd(3, 0, 4, "imm_l3");
    rd(4, 0, 0, "imm_l4");
    // pre-trigger wrap
    cfg(72'hFF, 72'h28, 5);
    do_arm();
    for (int i = 1; i <= 50; i++) begin
      smp(72'(i), 1'b1);
      if (i == 44) chk(K_STATE, "wrap_post", 2);
      if (i == 45) chk(K_STATE, "wrap_done", 3);
    end
    chk(K_CNT, "wrap_cnt", 16);
    chk(K_TIDX, "wrap_tidx", 10);
    rd(0, 0, 30, "wrap_l0");
    rd(10, 0, 32'h28, "wrap_l10");
    rd(15, 0, 45, "wrap_l15");
    // qualifier gating, then external trigger
    cfg(72'hFF, 72'h28, 5);
    do_arm();
    smp(72'h28, 1'b0);
    for (int i = 1; i <= 8; i++) smp(72'(i), 1'(i % 2));
    chk(K_TRIG, "gate_trig", 0);
    chk(K_STATE, "gate_state", 1);
    chk(K_CNT, "gate_cnt", 4);
    rd(1, 0, 3, "gate_l1");
    bus.ext_trig = 1'b1;
    smp(72'h99, 1'b0);
    chk(K_TRIG, "ext_unqual", 0);
    smp(72'h99, 1'b1);
    bus.ext_trig = 1'b0;
    chk(K_TRIG, "ext_trig", 1);
    chk(K_STATE, "ext_state", 2);
    chk(K_TIDX, "ext_tidx", 4);
    // maximum post-trigger count keeps the trigger sample as the oldest
    cfg(72'hFF, 72'h05, 15);
    do_arm();
    for (int i = 1; i <= 30; i++) begin
      smp(72'(i), 1'b1);
      if (i == 19) chk(K_STATE, "clamp_post", 2);
      if (i == 20) chk(K_STATE, "clamp_done", 3);
    end
    chk(K_CNT, "clamp_cnt", 16);
    chk(K_TIDX, "clamp_tidx", 0);
    rd(0, 0, 5, "clamp_l0");
    rd(15, 0, 20, "clamp_l15");
    // readback slicing with post_count 0
    cfg(72'h0, 72'h0, 0);
    do_arm();
    smp(72'hAB_12345678_9ABCDEF0, 1'b1);
    chk(K_STATE, "slice_done", 3);
    chk(K_CNT, "slice_cnt", 1);
    rd(0, 0, 32'h9ABCDEF0, "slice_w0");
    rd(0, 1, 32'h12345678, "slice_w1");
    rd(0, 2, 32'h000000AB, "slice_w2");
    rd(0, 3, 32'h0, "slice_w3");
    rd(0, 7, 32'h0, "slice_w7");
    rd(1, 0, 32'h0, "slice_beyond");
    // async reset during POSTTRIG
    cfg(72'h0, 72'h0, 10);
    do_arm();
    smp(72'h1, 1'b1);
    smp(72'h2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.state !== 2'd0) begin
      errors++;
      $display("FAIL async_state: got %0d expected 0", bus.state);
    end
    checks++;
    if (bus.samples_captured !== 5'd0) begin
      errors++;
      $display("FAIL async_cnt: got %0d expected 0", bus.samples_captured);
    end
    step();
    reset = 1'b0;
    smp(72'h3, 1'b1);
    chk(K_STATE, "reset_stays_idle", 0);
    chk(K_CNT, "reset_no_capture", 0);
    // clear wins over arm
    do_arm();
    smp(72'h1, 1'b1);
    bus.clear = 1'b1;
    bus.arm = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.arm = 1'b0;
    chk(K_STATE, "clear_arm_state", 0);
    chk(K_CNT, "clear_arm_cnt", 0);
    // arm during POSTTRIG restarts
    do_arm();
    smp(72'h1, 1'b1);
    smp(72'h2, 1'b1);
    chk(K_STATE, "rearm_pre", 2);
    do_arm();
    chk(K_STATE, "rearm_state", 1);
    chk(K_TRIG, "rearm_trig", 0);
    chk(K_CNT, "rearm_cnt", 0);
    repeat (4) step();
    if (q_due.size() > 0) begin
      errors += q_due.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_due.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
